// File: rtl/sum_accum.sv
// -----------------------------------------------------------------------------
// sum_accum
//   Streaming block accumulator placed behind the 32-bit adder (eq_n). Sums up
//   to COUNT_MAX unsigned samples (or fewer, when in_last closes the block
//   early) into an ACC_WIDTH-bit register. It then presents the total, the
//   sample count and a sticky carry-out flag on a valid/ready output port.
//
//   Parameters must satisfy ACC_WIDTH >= WIDTH and COUNT_MAX >= 1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sample present
//   in_ready   block can accept a sample (ACC state, out of reset)
//   in_data    unsigned sample, WIDTH bits
//   in_last    sample closes the block early (qualified by the handshake)
//   out_valid  block result present (OUT state)
//   out_ready  consumer accepts the result
//   out_data   block total modulo 2^ACC_WIDTH
//   out_count  samples in the block, 1..COUNT_MAX
//   out_ovf    total carried out of ACC_WIDTH at least once
//
// state | meaning
// ------+--------------------------------------------------------------
// ACC   | collecting samples, in_ready=1, out_valid=0
// OUT   | result held on the output port until out_ready, in_ready=0
// -----------------------------------------------------------------------------
module sum_accum #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int COUNT_MAX = 8,
    localparam int CW       = $clog2(COUNT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CW-1:0]        out_count,
    output logic                 out_ovf
);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 armed;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 ovf;

    logic                 in_fire;
    logic                 out_fire;
    logic [CW-1:0]        cnt_inc;
    logic [ACC_WIDTH:0]   sum;
    logic                 block_end;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign cnt_inc   = cnt + CW'(1);
    // One extra bit on top catches the carry out of the accumulator.
    assign sum       = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
    assign block_end = (cnt_inc == CW'(COUNT_MAX)) | in_last;

    // in_ready must stay low through reset and rise only on the first clock
    // after release, while the FSM itself resets straight into ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC: if (in_fire && block_end) state_nxt = ST_OUT;
            ST_OUT: if (out_ready)            state_nxt = ST_ACC;
            default:                          state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACC:  in_ready  = armed;
            ST_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // acc/cnt/ovf freeze in OUT, so they double as the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (in_fire) begin
            acc <= sum[ACC_WIDTH-1:0];
            cnt <= cnt_inc;
            ovf <= ovf | sum[ACC_WIDTH];
        end else if (out_fire) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

    assign out_data  = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accum.sv
module tb_sum_accum;

    localparam int AW = 40;
    localparam int BW = 33;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;

    logic          a_in_valid = 1'b0;
    logic          a_in_ready;
    logic [31:0]   a_in_data = '0;
    logic          a_in_last = 1'b0;
    logic          a_out_valid;
    logic          a_out_ready = 1'b0;
    logic [AW-1:0] a_out_data;
    logic [3:0]    a_out_count;
    logic          a_out_ovf;

    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [31:0]   b_in_data = '0;
    logic          b_in_last = 1'b0;
    logic          b_out_valid;
    logic          b_out_ready = 1'b1;
    logic [BW-1:0] b_out_data;
    logic [3:0]    b_out_count;
    logic          b_out_ovf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sum_accum u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    sum_accum #(.ACC_WIDTH(BW)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for instance A (block level) ----------
    bit            m_armed = 0;
    bit            m_ready = 0;
    bit            m_valid = 0;
    int            m_n = 0;
    longint        m_sum = 0;       // true (unwrapped) block sum
    logic [63:0]   e_data = '0;
    logic [63:0]   e_cnt = '0;
    logic [63:0]   e_ovf = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_armed = 0; m_ready = 0; m_valid = 0; m_n = 0; m_sum = 0;
            chk("rst_in_ready",  64'(a_in_ready),  64'd0);
            chk("rst_out_valid", 64'(a_out_valid), 64'd0);
            chk("rst_out_data",  64'(a_out_data),  64'd0);
            chk("rst_out_count", 64'(a_out_count), 64'd0);
            chk("rst_out_ovf",   64'(a_out_ovf),   64'd0);
        end else begin
            chk("mon_in_ready",  64'(a_in_ready),  64'(m_ready));
            chk("mon_out_valid", 64'(a_out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("mon_out_data",  64'(a_out_data),  e_data);
                chk("mon_out_count", 64'(a_out_count), e_cnt);
                chk("mon_out_ovf",   64'(a_out_ovf),   e_ovf);
            end
            // predict what the coming rising edge does
            if (!m_armed) begin
                m_armed = 1; m_ready = 1;
            end else if (m_ready && a_in_valid) begin
                m_n++;
                m_sum += longint'(a_in_data);
                if (m_n == 8 || a_in_last) begin
                    m_valid = 1; m_ready = 0;
                    e_data = 64'(m_sum) & ((64'd1 << AW) - 64'd1);
                    e_cnt  = 64'(m_n);
                    e_ovf  = (m_sum >= (longint'(1) << AW)) ? 64'd1 : 64'd0;
                end
            end else if (m_valid && a_out_ready) begin
                m_valid = 0; m_ready = 1; m_n = 0; m_sum = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic a_send(input logic [31:0] d, input logic l);
        bit done = 0;
        int n = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
        while (!done && n < 50) begin
            @(negedge clk);
            done = a_in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("a_send_timeout", 64'd0, 64'd1);
        a_in_valid = 1'b0; a_in_last = 1'($urandom); a_in_data = $urandom;
    endtask

    task automatic b_send(input logic [31:0] d, input logic l);
        bit done = 0;
        int n = 0;
        b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
        while (!done && n < 50) begin
            @(negedge clk);
            done = b_in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("b_send_timeout", 64'd0, 64'd1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic a_expect(input logic [63:0] d, input logic [63:0] c);
        chk("lit_out_valid", 64'(a_out_valid), 64'd1);
        chk("lit_out_data",  64'(a_out_data),  d);
        chk("lit_out_count", 64'(a_out_count), c);
        chk("lit_out_ovf",   64'(a_out_ovf),   64'd0);
    endtask

    task automatic a_drain();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_in_ready",  64'(a_in_ready),  64'd1);
        chk("post_hs_out_valid", 64'(a_out_valid), 64'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(a_in_ready), 64'd1);

        // full block 1..8
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) a_send(32'(i), 1'b0);
        a_expect(64'd36, 64'd8);
        a_drain();

        // early close
        a_send(32'h10, 1'b0);
        a_send(32'h20, 1'b1);
        a_expect(64'h30, 64'd2);
        a_drain();

        // backpressure with ignored input traffic
        a_out_ready = 1'b0;
        a_send(32'd3, 1'b0);
        a_send(32'd4, 1'b1);
        a_expect(64'd7, 64'd2);
        a_in_valid = 1'b1; a_in_data = 32'hFF;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
            chk("bp_out_data", 64'(a_out_data), 64'd7);
        end
        a_in_valid = 1'b0;
        a_drain();
        a_send(32'd1, 1'b1);
        a_expect(64'd1, 64'd1);
        a_drain();

        // reset mid-block
        for (int i = 0; i < 3; i++) a_send(32'd9, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("after_rst_out_valid", 64'(a_out_valid), 64'd0);
        for (int i = 0; i < 8; i++) a_send(32'd5, 1'b0);
        a_expect(64'd40, 64'd8);
        a_drain();

        // randomized traffic, checked by the model
        for (int c = 0; c < 400; c++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            a_in_last   = ($urandom_range(0, 4) == 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // carry-out on a 33-bit accumulator
        b_out_ready = 1'b1;
        b_send(32'hFFFF_FFFF, 1'b0);
        b_send(32'hFFFF_FFFF, 1'b1);
        chk("ovf2_valid", 64'(b_out_valid), 64'd1);
        chk("ovf2_data",  64'(b_out_data),  64'h1_FFFF_FFFE);
        chk("ovf2_count", 64'(b_out_count), 64'd2);
        chk("ovf2_ovf",   64'(b_out_ovf),   64'd0);
        @(posedge clk); #1;
        b_send(32'hFFFF_FFFF, 1'b0);
        b_send(32'hFFFF_FFFF, 1'b0);
        b_send(32'hFFFF_FFFF, 1'b1);
        chk("ovf3_valid", 64'(b_out_valid), 64'd1);
        chk("ovf3_data",  64'(b_out_data),  64'h0_FFFF_FFFD);
        chk("ovf3_count", 64'(b_out_count), 64'd3);
        chk("ovf3_ovf",   64'(b_out_ovf),   64'd1);
        @(posedge clk); #1;
        chk("ovf_cleared_valid", 64'(b_out_valid), 64'd0);
        chk("ovf_cleared_ovf",   64'(b_out_ovf),   64'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_accum.md
Name: sum_accum

Overview:
- Streaming accumulator that sits directly downstream of the team's 32-bit adder (eq_n).
- Consumes one 32-bit unsigned sum per handshake and accumulates a block of up to COUNT_MAX samples into a wider register.
- Presents the block total, the sample count and a sticky overflow flag on a valid/ready output port.
- Provides block-level reduction for the datapath; in_last allows early block termination.

Parameters:
- WIDTH, 32, input sample width (matches eq_n sum).
- ACC_WIDTH, 40, accumulator and output width; must be >= WIDTH.
- COUNT_MAX, 8, samples per full block; must be >= 1.
- CW, $clog2(COUNT_MAX+1), width of the count field (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample present.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  unsigned sample (eq_n sum).
- in_last  input  1  sample closes the block early; qualified by the handshake.
- out_valid  output  1  block result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_WIDTH  accumulated total, modulo 2^ACC_WIDTH.
- out_count  output  CW  number of samples in the block, 1..COUNT_MAX.
- out_ovf  output  1  accumulation carried out of ACC_WIDTH at least once.

Behaviour:
- Reset (async assert, sync release): state=ACC, acc=0, cnt=0, ovf=0. Outputs: in_ready=0 while rst_n=0 and 1 from the first cycle after release; out_valid=0, out_data=0, out_count=0, out_ovf=0.
- Reset mid-block or mid-output discards all partial data; no result is emitted for a discarded block.
- States:
  - ACC: in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Input accept = in_valid & in_ready, in ACC only. On accept:
  - acc <= acc + zero_ext(in_data), truncated to ACC_WIDTH.
  - ovf <= ovf | carry out of bit ACC_WIDTH-1.
  - cnt <= cnt + 1.
- ACC -> OUT on an accept where cnt+1 == COUNT_MAX or in_last=1. out_valid rises the cycle after that final accept, so the latency from last sample to result is 1 cycle.
- OUT: out_data, out_count and out_ovf are registered and held stable while out_valid=1 and out_ready=0. Inputs are ignored because in_ready=0.
- Output handshake (out_valid & out_ready) in OUT clears acc, cnt and ovf and returns to ACC; in_ready=1 on the next cycle.
  - No input is accepted in the handshake cycle, so sample ordering between blocks is trivially preserved.
  - Throughput: one block per (samples + 1) cycles minimum.
- out_ready asserted while in ACC has no effect.
- in_last on the COUNT_MAX-th sample produces the same result as without it (single close, count=COUNT_MAX).
- in_last on the first sample gives a block of count 1.
- Values presented on in_data or in_last without in_valid are ignored.
- No combinational path from any input to any output except none at all: in_ready depends only on state; out_valid and out data are register outputs.
- Arithmetic is unsigned only; no saturation, wrap modulo 2^ACC_WIDTH.

Test Plan:
- Reset check: rst_n=0 -> in_ready=0, out_valid=0, out_data=0, out_count=0, out_ovf=0. Release rst_n -> in_ready=1 on the next cycle.
- Full block, default params: 8 back-to-back samples 1..8 with out_ready=1 -> out_valid one cycle after the 8th accept, out_data=36, out_count=8, out_ovf=0. in_ready=1 again the cycle after the output handshake.
- Early close: samples 0x10, 0x20 with in_last on the second -> out_data=0x30, out_count=2. Next block starts from acc=0.
- Backpressure: hold out_ready=0 for 5 cycles in OUT while driving in_valid=1 with 0xFF -> in_ready=0, outputs stable, no sample absorbed. Release -> result unchanged.
- Overflow, ACC_WIDTH=33: two samples 0xFFFFFFFF with in_last on the second -> out_data=0x1_FFFFFFFE, out_ovf=0. Three samples 0xFFFFFFFF with in_last on the third -> out_data=0x0_FFFFFFFD, out_ovf=1.
- Reset mid-block: accept 3 samples, pulse rst_n low -> no out_valid. Next full block of 8×5 -> out_data=40, out_count=8.
